game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Crane-game round timer that sits directly upstream of the 7-segment display controller.
- Counts down a play period in whole seconds, MM:SS format, held internally as four BCD digits so the display stage needs no division.
- Provides start, pause and bonus-time controls from game logic, and a one-cycle expiry pulse that ends the claw round.

Parameters:
- TICK_CYCLES, 100000000, clock cycles per one-second tick (set small for simulation).
- START_MIN, 1, minutes loaded on start (0..99).
- START_SEC, 0, seconds loaded on start (0..59).
- BONUS_SEC, 10, seconds added per bonus pulse (1..59).

Ports:
- clock_100Mhz  input  1  system clock.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  pulse: load START_MIN:START_SEC and run.
- pause  input  1  level: freezes countdown while high in RUN.
- bonus  input  1  pulse: add BONUS_SEC seconds.
- bcd_digits  output  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each, to the display stage.
- running  output  1  high in RUN state with pause low.
- expired  output  1  one-cycle pulse when time reaches 00:00.
- state_out  output  2  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3.

Behaviour:
- Reset (async, reset_n low): state IDLE, bcd_digits=16'h0000, running=0, expired=0, tick counter=0.
- Tick generator: counter 0..TICK_CYCLES-1, counts only in RUN with pause low; tick asserted when the counter equals TICK_CYCLES-1, then wraps to 0. Counter clears on start. It holds, and does not clear, while paused.
- FSM transitions:
  - IDLE: start -> RUN with digits loaded. Digits hold 00:00 on entry after reset.
  - RUN: pause high -> PAUSED. A tick at 00:01 -> EXPIRED.
  - PAUSED: pause low -> RUN; the tick counter resumes from its held value.
  - EXPIRED: digits hold 00:00; start -> RUN with reload.
  - In every state, start reloads START_MIN:START_SEC, clears the tick counter and enters RUN. Start wins over pause and bonus in the same cycle.
- Decrement on tick: sec_ones-1. On borrow, sec_ones=9 and sec_tens-1. When sec_tens borrows, sec_tens=5 and minutes decrement the same way (ones 0->9, tens-1). There is no decrement below 00:00.
- Bonus: accepted only in RUN or PAUSED and ignored in IDLE/EXPIRED. Adds BONUS_SEC with BCD carry; sec_tens carries at 6 into minutes. The result saturates at 99:59.
- Tick and bonus in the same cycle: the net result is value-1+BONUS_SEC, saturated. If the value is 00:01, the result is BONUS_SEC seconds and the timer does not expire.
- Latency: digits update on the clock edge after a tick, bonus or start. expired pulses in the same cycle the digits become 00:00 and state becomes EXPIRED.
- running is combinational from state and pause. It is low in PAUSED and low in RUN while pause is high before the state change.
- Mid-operation reset: everything returns to reset values immediately, and no expired pulse is emitted.
- All digit registers stay in BCD range 0..9; tens of seconds stay in 0..5.

Test Plan:
1. TICK_CYCLES=4, START 0:03, start pulse -> digits 00:03, 00:02, 00:01, 00:00 every 4 cycles; expired high exactly 1 cycle at 00:00; state_out=3.
2. START 1:00, one tick -> 00:59; START 10:00, one tick -> 09:59 (borrow across both tens fields).
3. Running at 00:30 with tick counter at 2, pause high for 20 cycles -> digits frozen at 00:30 and running=0. After release, the next tick comes 2 cycles later -> 00:29.
4. bonus at 00:55 -> 01:05; bonus at 99:55 -> 99:59 (saturate); bonus in IDLE -> no change; tick+bonus at 00:01 -> 00:10, no expired.
5. start while in EXPIRED and while in PAUSED -> reload to START value, state RUN, tick counter restarts (first tick exactly TICK_CYCLES cycles later); start+pause same cycle -> RUN.
6. reset_n low asynchronously mid-count (no clock edge) -> bcd_digits=0000, state IDLE, expired stays 0.

Source files
------------

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: crane-game round timer. Counts a play period down in
// whole seconds, held as four BCD digits {min_tens, min_ones, sec_tens,
// sec_ones} so the 7-segment stage downstream can display them directly.
module game_countdown_timer #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned START_MIN   = 1,
    parameter int unsigned START_SEC   = 0,
    parameter int unsigned BONUS_SEC   = 10
) (
    input  logic        clock_100Mhz,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic        bonus,
    output logic [15:0] bcd_digits,
    output logic        running,
    output logic        expired,
    output logic [1:0]  state_out
);

    // Control interface: start and bonus are single-cycle pulses and pause is
    // a level, all sampled on the rising clock edge. There is no back-pressure:
    // a pulse is either acted on in the cycle it is seen or ignored when the
    // current state does not accept it. Start has priority over everything.

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    localparam logic [15:0] START_BCD = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                         4'(START_SEC / 10), 4'(START_SEC % 10)};
    localparam logic [3:0]  BONUS_ONES = 4'(BONUS_SEC % 10);
    localparam logic [3:0]  BONUS_TENS = 4'(BONUS_SEC / 10);
    localparam logic [15:0] MAX_BCD    = 16'h9959;

    logic [1:0]    state;
    logic [15:0]   digits;
    logic [CW-1:0] tick_cnt;
    logic          run_active;
    logic          tick;
    logic [15:0]   digits_dec;
    logic [15:0]   digits_bonus;
    logic [15:0]   digits_tick_bonus;

    // One-second BCD decrement with borrow; 00:00 stays at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v == 16'h0000) begin
            r = v;
        end else if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Add BONUS_SEC digit by digit; seconds-tens carry at 6, result caps at 99:59.
    function automatic logic [15:0] bcd_add_bonus(input logic [15:0] v);
        logic [4:0]  so;
        logic [4:0]  st;
        logic [4:0]  mo;
        logic [4:0]  mt;
        logic [15:0] r;
        so = {1'b0, v[3:0]} + {1'b0, BONUS_ONES};
        st = {1'b0, v[7:4]} + {1'b0, BONUS_TENS};
        if (so >= 5'd10) begin
            so = so - 5'd10;
            st = st + 5'd1;
        end
        mo = {1'b0, v[11:8]};
        if (st >= 5'd6) begin
            st = st - 5'd6;
            mo = mo + 5'd1;
        end
        mt = {1'b0, v[15:12]};
        if (mo >= 5'd10) begin
            mo = mo - 5'd10;
            mt = mt + 5'd1;
        end
        if (mt >= 5'd10) begin
            r = MAX_BCD;
        end else begin
            r = {mt[3:0], mo[3:0], st[3:0], so[3:0]};
        end
        return r;
    endfunction

    // Tick strobe and candidate next digit values for tick, bonus and both.
    always_comb begin
        run_active        = (state == S_RUN) && !pause;
        tick              = run_active && (tick_cnt == TICK_LAST);
        digits_dec        = bcd_dec(digits);
        digits_bonus      = bcd_add_bonus(digits);
        digits_tick_bonus = bcd_add_bonus(digits_dec);
    end

    // Tick counter: cleared by start, counts only while actively running, holds otherwise.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (start) begin
            tick_cnt <= '0;
        end else if (run_active) begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
        end
    end

    // Round FSM, digit register and registered one-cycle expiry pulse.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            digits  <= 16'h0000;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (start) begin
                state  <= S_RUN;
                digits <= START_BCD;
            end else begin
                case (state)
                    S_RUN: begin
                        if (tick && bonus) begin
                            digits <= digits_tick_bonus;
                        end else if (tick) begin
                            digits <= digits_dec;
                            if (digits_dec == 16'h0000) begin
                                state   <= S_EXPIRED;
                                expired <= 1'b1;
                            end
                        end else if (bonus) begin
                            digits <= digits_bonus;
                        end
                        if (pause) begin
                            state <= S_PAUSED;
                        end
                    end
                    S_PAUSED: begin
                        if (bonus) begin
                            digits <= digits_bonus;
                        end
                        if (!pause) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign running    = (state == S_RUN) && !pause;
    assign bcd_digits = digits;
    assign state_out  = state;

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: directed bench for game_countdown_timer with an
// event scoreboard on {expired, state_out, bcd_digits} plus point checks.
module tb_game_countdown_timer;

    localparam int TICKS    = 4;
    localparam int MAX_SECS = 99 * 60 + 59;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        pause   = 1'b0;
    logic        bonus   = 1'b0;
    logic [15:0] bcd_digits;
    logic        running;
    logic        expired;
    logic [1:0]  state_out;

    game_countdown_timer #(
        .TICK_CYCLES(TICKS),
        .START_MIN  (0),
        .START_SEC  (3),
        .BONUS_SEC  (10)
    ) dut (
        .clock_100Mhz(clk),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .bonus       (bonus),
        .bcd_digits  (bcd_digits),
        .running     (running),
        .expired     (expired),
        .state_out   (state_out)
    );

    // Clock and cycle counter (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected output events and the cycle each must appear in.
    logic [18:0] exp_q[$];
    int          exp_t_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur = 0;
    int          next_tick = 0;
    int          paused_at = 0;
    int          c = 0;
    logic [18:0] prev_obs = '0;
    logic [18:0] obs;
    logic [18:0] exp_ev;
    int          exp_t;

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_ev(input int secs, input logic [1:0] st, input logic ex, input int t);
        exp_q.push_back({ex, st, to_bcd(secs)});
        exp_t_q.push_back(t);
    endtask

    // Monitor: every change of the observed tuple is matched against the queue.
    always @(negedge clk) begin
        obs = {expired, state_out, bcd_digits};
        if (obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", obs, cyc);
            end else begin
                exp_ev = exp_q.pop_front();
                exp_t  = exp_t_q.pop_front();
                if (obs !== exp_ev || cyc != exp_t) begin
                    errors++;
                    $display("FAIL event: got %h at cycle %0d, expected %h at cycle %0d",
                             obs, cyc, exp_ev, exp_t);
                end
            end
            prev_obs = obs;
        end
    end

    // Driver tasks: all called at (or just after) a falling edge.
    task automatic do_start();
        c = cyc;
        start = 1'b1;
        cur = 3;
        push_ev(cur, S_RUN, 1'b0, c + 1);
        next_tick = c + 1 + TICKS;
        @(negedge clk);
        start = 1'b0;
        #1 chk("running_after_start", 32'(running), 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        int t;
        int last;
        last = cyc;
        for (int i = 0; i < n; i++) begin
            t = next_tick + i * TICKS;
            cur = cur - 1;
            if (cur == 0) begin
                push_ev(0, S_EXPIRED, 1'b1, t);
                push_ev(0, S_EXPIRED, 1'b0, t + 1);
                last = t + 1;
            end else begin
                push_ev(cur, S_RUN, 1'b0, t);
                last = t;
            end
        end
        next_tick = next_tick + n * TICKS;
        while (cyc < last) @(negedge clk);
    endtask

    task automatic tick_bonus();
        while (cyc < next_tick - 1) @(negedge clk);
        bonus = 1'b1;
        cur = (cur - 1 + 10 > MAX_SECS) ? MAX_SECS : cur - 1 + 10;
        push_ev(cur, S_RUN, 1'b0, next_tick);
        @(negedge clk);
        bonus = 1'b0;
        next_tick = next_tick + TICKS;
    endtask

    task automatic bonus_pulses(input int n);
        int nv;
        for (int i = 0; i < n; i++) begin
            bonus = 1'b1;
            nv = (cur + 10 > MAX_SECS) ? MAX_SECS : cur + 10;
            if (nv != cur) push_ev(nv, S_PAUSED, 1'b0, cyc + 1);
            cur = nv;
            @(negedge clk);
        end
        bonus = 1'b0;
    endtask

    task automatic pause_on();
        pause = 1'b1;
        paused_at = cyc;
        push_ev(cur, S_PAUSED, 1'b0, cyc + 1);
        #1 chk("running_low_on_pause", 32'(running), 32'd0);
        @(negedge clk);
    endtask

    task automatic pause_off();
        pause = 1'b0;
        push_ev(cur, S_RUN, 1'b0, cyc + 1);
        next_tick = next_tick + (cyc - paused_at + 1);
        @(negedge clk);
        #1 chk("running_after_release", 32'(running), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("reset_digits", 32'(bcd_digits), 32'h0000);
        chk("reset_state", 32'(state_out), 32'(S_IDLE));
        chk("reset_expired", 32'(expired), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Bonus ignored in IDLE
        bonus = 1'b1;
        @(negedge clk);
        bonus = 1'b0;
        @(negedge clk);
        #1 chk("idle_bonus_digits", 32'(bcd_digits), 32'h0000);
        chk("idle_bonus_state", 32'(state_out), 32'(S_IDLE));

        // 00:03 countdown to expiry, one tick every TICKS cycles
        do_start();
        chk("start_digits", 32'(bcd_digits), 32'h0003);
        wait_ticks(3);
        #1 chk("expired_state", 32'(state_out), 32'(S_EXPIRED));
        chk("expired_digits", 32'(bcd_digits), 32'h0000);

        // Bonus ignored in EXPIRED
        bonus = 1'b1;
        @(negedge clk);
        bonus = 1'b0;
        @(negedge clk);
        #1 chk("expired_bonus_digits", 32'(bcd_digits), 32'h0000);

        // Start from EXPIRED reloads; tick+bonus at 00:01 gives 00:10, no expiry
        do_start();
        wait_ticks(2);
        tick_bonus();
        #1 chk("tick_bonus_digits", 32'(bcd_digits), 32'h0010);
        chk("tick_bonus_state", 32'(state_out), 32'(S_RUN));

        // Build 01:00 with bonuses, one tick borrows to 00:59
        pause_on();
        bonus_pulses(5);
        #1 chk("bonus_to_0100", 32'(bcd_digits), 32'h0100);
        pause_off();
        wait_ticks(1);
        #1 chk("borrow_0059", 32'(bcd_digits), 32'h0059);

        // 00:55 + bonus carries into minutes
        wait_ticks(4);
        pause_on();
        bonus_pulses(1);
        #1 chk("bonus_0105", 32'(bcd_digits), 32'h0105);
        pause_off();

        // Build 10:00, one tick borrows across both tens fields
        wait_ticks(5);
        pause_on();
        bonus_pulses(54);
        #1 chk("bonus_to_1000", 32'(bcd_digits), 32'h1000);
        pause_off();
        wait_ticks(1);
        #1 chk("borrow_0959", 32'(bcd_digits), 32'h0959);

        // Saturation at 99:59
        wait_ticks(4);
        pause_on();
        bonus_pulses(540);
        #1 chk("bonus_to_9955", 32'(bcd_digits), 32'h9955);
        bonus_pulses(1);
        #1 chk("bonus_saturate", 32'(bcd_digits), 32'h9959);
        bonus_pulses(1);
        #1 chk("bonus_hold_max", 32'(bcd_digits), 32'h9959);
        pause_off();

        // Pause with tick counter at 2 for 20 cycles; counter resumes from held value
        wait_ticks(1);
        while (cyc < next_tick - 2) @(negedge clk);
        pause_on();
        repeat (10) @(negedge clk);
        #1 chk("pause_frozen_mid", 32'(bcd_digits), 32'h9958);
        chk("pause_running_mid", 32'(running), 32'd0);
        chk("pause_state_mid", 32'(state_out), 32'(S_PAUSED));
        repeat (9) @(negedge clk);
        pause_off();
        wait_ticks(1);
        #1 chk("after_pause_tick", 32'(bcd_digits), 32'h9957);

        // Start while PAUSED (pause released same cycle) reloads and restarts counter
        pause_on();
        repeat (3) @(negedge clk);
        c = cyc;
        start = 1'b1;
        pause = 1'b0;
        cur = 3;
        push_ev(cur, S_RUN, 1'b0, c + 1);
        next_tick = c + 1 + TICKS;
        @(negedge clk);
        start = 1'b0;
        #1 chk("start_from_paused_state", 32'(state_out), 32'(S_RUN));
        wait_ticks(1);

        // Start and pause in the same cycle: start wins, pause takes effect next edge
        c = cyc;
        start = 1'b1;
        pause = 1'b1;
        cur = 3;
        push_ev(cur, S_RUN, 1'b0, c + 1);
        push_ev(cur, S_PAUSED, 1'b0, c + 2);
        paused_at = c + 1;
        next_tick = c + 1 + TICKS;
        @(negedge clk);
        start = 1'b0;
        #1 chk("start_wins_over_pause", 32'(state_out), 32'(S_RUN));
        repeat (3) @(negedge clk);
        pause_off();
        wait_ticks(3);
        #1 chk("second_expiry_state", 32'(state_out), 32'(S_EXPIRED));

        // Asynchronous reset mid-count, between clock edges
        do_start();
        wait_ticks(1);
        @(negedge clk);
        push_ev(0, S_IDLE, 1'b0, cyc + 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_digits", 32'(bcd_digits), 32'h0000);
        chk("async_reset_state", 32'(state_out), 32'(S_IDLE));
        chk("async_reset_expired", 32'(expired), 32'd0);
        chk("async_reset_running", 32'(running), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #1 chk("post_reset_idle", 32'(state_out), 32'(S_IDLE));

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
